// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: main sequencing FSM plus ALU decoder.
// Outputs are Moore-decoded from the state; PCEn also uses Zero, and ALUControl/Illegal also use Funct.
module mips_multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               PCEn,
  output logic               IorD,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUControl,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_EXECUTE = STATE_W'(6),
    S_ALUWB   = STATE_W'(7),
    S_BRANCH  = STATE_W'(8),
    S_ADDIEX  = STATE_W'(9),
    S_ADDIWB  = STATE_W'(10),
    S_JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  state_t     w_dec_state;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_op_illegal;
  logic       w_funct_illegal;
  logic [1:0] w_aluop;

  // State register; reset overrides any transition.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  assign State = r_state;

  // While reset is held the outputs present FETCH values with enables masked.
  assign w_dec_state = reset ? S_FETCH : r_state;

  // Next-state logic; Op is read directly from the held IR field.
  always_comb begin
    w_next       = S_FETCH;
    w_op_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next       = S_FETCH;
            w_op_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore output decode.
  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_aluop    = 2'b00;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    case (w_dec_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:   IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        w_aluop = 2'b10;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluop  = 2'b01;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB:  w_regwrite = 1'b1;
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; an unknown funct falls back to add and is flagged.
  always_comb begin
    ALUControl      = 3'b010;
    w_funct_illegal = 1'b0;
    case (w_aluop)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   w_funct_illegal = 1'b1;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  assign Illegal  = ~reset & (w_op_illegal | w_funct_illegal);
  assign MemWrite = ~reset & w_memwrite;
  assign IRWrite  = ~reset & w_irwrite;
  assign RegWrite = ~reset & w_regwrite;
  assign PCEn     = ~reset & (w_pcwrite | (w_branch & Zero));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class and checks
// state and the full output vector every cycle against hand-derived values.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemWrite, IRWrite, RegWrite, PCEn, IorD, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       Illegal;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCEn(PCEn),
    .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .Illegal(Illegal),
    .State(State)
  );

  always #5 clk = ~clk;

  // {MemWrite,IRWrite,RegWrite,PCEn, IorD,RegDst,MemtoReg,ALUSrcA, ALUSrcB, PCSrc, ALUControl, Illegal}
  logic [15:0] w_vec;
  assign w_vec = {MemWrite, IRWrite, RegWrite, PCEn, IorD, RegDst, MemtoReg, ALUSrcA,
                  ALUSrcB, PCSrc, ALUControl, Illegal};

  localparam logic [15:0] V_RST     = 16'b0000_0000_01_00_010_0;
  localparam logic [15:0] V_FETCH   = 16'b0101_0000_01_00_010_0;
  localparam logic [15:0] V_DEC     = 16'b0000_0000_11_00_010_0;
  localparam logic [15:0] V_DEC_ILL = 16'b0000_0000_11_00_010_1;
  localparam logic [15:0] V_MEMADR  = 16'b0000_0001_10_00_010_0;
  localparam logic [15:0] V_MEMRD   = 16'b0000_1000_00_00_010_0;
  localparam logic [15:0] V_MEMWB   = 16'b0010_0010_00_00_010_0;
  localparam logic [15:0] V_MEMWR   = 16'b1000_1000_00_00_010_0;
  localparam logic [15:0] V_EX_SUB  = 16'b0000_0001_00_00_110_0;
  localparam logic [15:0] V_EX_SLT  = 16'b0000_0001_00_00_111_0;
  localparam logic [15:0] V_EX_AND  = 16'b0000_0001_00_00_000_0;
  localparam logic [15:0] V_EX_OR   = 16'b0000_0001_00_00_001_0;
  localparam logic [15:0] V_EX_ILL  = 16'b0000_0001_00_00_010_1;
  localparam logic [15:0] V_ALUWB   = 16'b0010_0100_00_00_010_0;
  localparam logic [15:0] V_BR_Z1   = 16'b0001_0001_00_01_110_0;
  localparam logic [15:0] V_BR_Z0   = 16'b0000_0001_00_01_110_0;
  localparam logic [15:0] V_ADDIEX  = 16'b0000_0001_10_00_010_0;
  localparam logic [15:0] V_ADDIWB  = 16'b0010_0000_00_00_010_0;
  localparam logic [15:0] V_JUMP    = 16'b0001_0000_00_10_010_0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle mid-period, then advance just past the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] v);
    @(negedge clk);
    check_eq({tag, "_state"}, 32'(State), 32'(st));
    check_eq({tag, "_outs"}, 32'(w_vec), 32'(v));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    Op    = 6'b100011;
    Funct = 6'b100000;
    Zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 4'd0, V_RST);
    reset = 1'b0;

    Op = 6'b100011;
    cyc("lw_f", 4'd0, V_FETCH);
    cyc("lw_d", 4'd1, V_DEC);
    cyc("lw_ma", 4'd2, V_MEMADR);
    cyc("lw_mr", 4'd3, V_MEMRD);
    cyc("lw_wb", 4'd4, V_MEMWB);

    Op = 6'b101011;
    cyc("sw_f", 4'd0, V_FETCH);
    cyc("sw_d", 4'd1, V_DEC);
    cyc("sw_ma", 4'd2, V_MEMADR);
    cyc("sw_mw", 4'd5, V_MEMWR);

    Op = 6'b000000;
    Funct = 6'b100010;
    cyc("sub_f", 4'd0, V_FETCH);
    cyc("sub_d", 4'd1, V_DEC);
    cyc("sub_ex", 4'd6, V_EX_SUB);
    cyc("sub_wb", 4'd7, V_ALUWB);
    Funct = 6'b101010;
    cyc("slt_f", 4'd0, V_FETCH);
    cyc("slt_d", 4'd1, V_DEC);
    cyc("slt_ex", 4'd6, V_EX_SLT);
    cyc("slt_wb", 4'd7, V_ALUWB);
    Funct = 6'b100100;
    cyc("and_f", 4'd0, V_FETCH);
    cyc("and_d", 4'd1, V_DEC);
    cyc("and_ex", 4'd6, V_EX_AND);
    cyc("and_wb", 4'd7, V_ALUWB);
    Funct = 6'b100101;
    cyc("or_f", 4'd0, V_FETCH);
    cyc("or_d", 4'd1, V_DEC);
    cyc("or_ex", 4'd6, V_EX_OR);
    cyc("or_wb", 4'd7, V_ALUWB);
    Funct = 6'b000000;
    cyc("fill_f", 4'd0, V_FETCH);
    cyc("fill_d", 4'd1, V_DEC);
    cyc("fill_ex", 4'd6, V_EX_ILL);
    cyc("fill_wb", 4'd7, V_ALUWB);

    Op = 6'b001000;
    cyc("addi_f", 4'd0, V_FETCH);
    cyc("addi_d", 4'd1, V_DEC);
    cyc("addi_ex", 4'd9, V_ADDIEX);
    cyc("addi_wb", 4'd10, V_ADDIWB);

    // beq taken, with Zero toggled inside the BRANCH cycle
    Op = 6'b000100;
    cyc("beq1_f", 4'd0, V_FETCH);
    cyc("beq1_d", 4'd1, V_DEC);
    Zero = 1'b1;
    @(negedge clk);
    check_eq("beq1_br_state", 32'(State), 32'd8);
    check_eq("beq1_br_outs", 32'(w_vec), 32'(V_BR_Z1));
    Zero = 1'b0;
    #1;
    check_eq("beq1_zero_drop", 32'(PCEn), 32'd0);
    Zero = 1'b1;
    #1;
    check_eq("beq1_zero_rise", 32'(PCEn), 32'd1);
    @(posedge clk);
    #1;
    Zero = 1'b0;
    cyc("beq0_f", 4'd0, V_FETCH);
    cyc("beq0_d", 4'd1, V_DEC);
    cyc("beq0_br", 4'd8, V_BR_Z0);

    Op = 6'b000010;
    cyc("j_f", 4'd0, V_FETCH);
    cyc("j_d", 4'd1, V_DEC);
    cyc("j_j", 4'd11, V_JUMP);

    Op = 6'b111111;
    cyc("ill_f", 4'd0, V_FETCH);
    cyc("ill_d", 4'd1, V_DEC_ILL);
    cyc("ill_back", 4'd0, V_FETCH);

    // Reset held two cycles starting mid-EXECUTE
    Op = 6'b000000;
    Funct = 6'b100000;
    cyc("rex_d", 4'd1, V_DEC);
    reset = 1'b1;
    cyc("rex_ex", 4'd6, V_RST);
    cyc("rex_hold", 4'd0, V_RST);
    reset = 1'b0;
    cyc("rex_f", 4'd0, V_FETCH);
    cyc("rex_d2", 4'd1, V_DEC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
